// File: rtl/dro_bank_pkg.sv
// dro_bank_pkg: shared controller state type and count-width helper for dro_bank
package dro_bank_pkg;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dro_bank_cell.sv
// dro_bank_cell: one storage channel (fluxon count, readout toggle, overflow, hold check)
// Ports: clk, rst; i_run gates events; i_set_ev/i_read_ev are decoded pulses;
// o_count fluxon count, o_out readout toggle, o_ovf sticky overflow, o_viol sticky hold violation.
// Optional hold-window checking under `DRO_BANK_HOLD_CHECK_EN.
module dro_bank_cell import dro_bank_pkg::*; #(
  parameter int DEPTH = 1
`ifdef DRO_BANK_HOLD_CHECK_EN
  , parameter int HOLD_CYCLES = 3
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_run,
  input  logic                          i_set_ev,
  input  logic                          i_read_ev,
  output logic [clog2_p1(DEPTH)-1:0]    o_count,
  output logic                          o_out,
  output logic                          o_ovf,
  output logic                          o_viol
);
  localparam int CW = clog2_p1(DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);
  logic [CW-1:0] r_cnt, w_mid, w_nxt;
  logic r_out, r_ovf, w_rd, w_st, w_full;
  // the read acts on the pre-edge count first, so a full channel read and set together does not overflow
  always_comb begin
    w_rd = i_run & i_read_ev & (r_cnt != '0);
    w_st = i_run & i_set_ev;
    w_mid = w_rd ? r_cnt - CW'(1) : r_cnt;
    w_full = w_mid == CMAX;
    w_nxt = (w_st & ~w_full) ? w_mid + CW'(1) : w_mid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_nxt;
      r_out <= r_out ^ w_rd;
      r_ovf <= r_ovf | (w_st & w_full);
    end
  end
  assign o_count = r_cnt;
  assign o_out = r_out;
  assign o_ovf = r_ovf;
`ifdef DRO_BANK_HOLD_CHECK_EN
  localparam int HW = clog2_p1(HOLD_CYCLES) > 0 ? clog2_p1(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);
  logic [HW-1:0] r_ss, r_sr;
  logic r_viol, w_viol, w_rev;
  // counters hold the distance to the last event; loading 1 makes a gap of exactly HOLD_CYCLES legal
  always_comb begin
    w_rev = i_run & i_read_ev;
    w_viol = i_run & ((i_set_ev & i_read_ev) | (i_set_ev & (r_sr < HMAX)) | (i_read_ev & (r_ss < HMAX)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss <= HMAX;
      r_sr <= HMAX;
      r_viol <= 1'b0;
    end else begin
      r_ss <= w_st ? HW'(1) : (r_ss < HMAX ? r_ss + HW'(1) : r_ss);
      r_sr <= w_rev ? HW'(1) : (r_sr < HMAX ? r_sr + HW'(1) : r_sr);
      r_viol <= r_viol | w_viol;
    end
  end
  assign o_viol = r_viol;
`else
  assign o_viol = 1'b0;
`endif
endmodule

// File: rtl/dro_bank.sv
// dro_bank: CHANNELS-wide destructive-readout bank with toggle-encoded SFQ pulses
// Ports: clk, rst (sync, active-high); set_i per-channel set pulses; read_i shared read pulse;
// out_o readout toggles; count_o packed per-channel counts; ready_o init done;
// overflow_o sticky overflow; viol_o sticky hold violation (only with `DRO_BANK_HOLD_CHECK_EN).
module dro_bank import dro_bank_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int DEPTH = 1,
  parameter int BEGIN_CYCLES = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CHANNELS-1:0]                    set_i,
  input  logic                                   read_i,
  output logic [CHANNELS-1:0]                    out_o,
  output logic [CHANNELS*clog2_p1(DEPTH)-1:0]    count_o,
  output logic                                   ready_o,
  output logic [CHANNELS-1:0]                    overflow_o,
  output logic [CHANNELS-1:0]                    viol_o
);
  localparam int CW = clog2_p1(DEPTH);
  localparam int BW = BEGIN_CYCLES > 1 ? $clog2(BEGIN_CYCLES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BEGIN_CYCLES > 0 ? BEGIN_CYCLES - 1 : 0);
  state_t r_state, w_state;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic [CHANNELS-1:0] r_prev_set, w_set_ev;
  logic r_prev_read, w_read_ev, w_run;
  // previous samples load even during reset so held levels are not seen as pulses at release
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_bcnt <= '0;
    end else begin
      r_state <= w_state;
      r_bcnt <= w_bcnt;
    end
    r_prev_set <= set_i;
    r_prev_read <= read_i;
  end
  always_comb begin
    w_run = r_state == RUN;
    w_state = (w_run || BEGIN_CYCLES == 0 || r_bcnt == BLAST) ? RUN : INIT;
    w_bcnt = w_run ? r_bcnt : r_bcnt + BW'(1);
    w_set_ev = set_i ^ r_prev_set;
    w_read_ev = read_i ^ r_prev_read;
  end
  assign ready_o = w_run;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    dro_bank_cell #(
      .DEPTH(DEPTH)
`ifdef DRO_BANK_HOLD_CHECK_EN
      , .HOLD_CYCLES(HOLD_CYCLES)
`endif
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .i_run(w_run),
      .i_set_ev(w_set_ev[k]),
      .i_read_ev(w_read_ev),
      .o_count(count_o[k*CW +: CW]),
      .o_out(out_o[k]),
      .o_ovf(overflow_o[k]),
      .o_viol(viol_o[k])
    );
  end
endmodule

// File: doc/dro_bank.md
Name: dro_bank

Overview:
- Clocked, parametrised successor to the single-fluxon destructive-readout cell: CHANNELS independent storage channels, each holding up to DEPTH fluxons.
- SFQ pulses are toggle-encoded: every transition of an input, rising or falling, is one pulse.
- A shared read pulse destructively reads every non-empty channel. Each such channel toggles its output and releases one fluxon.
- Sits in the cell-model library as a synthesizable reference for vcd_assert traces, with built-in hold-window checking.

Parameters:
- CHANNELS, 4: number of independent storage channels.
- DEPTH, 1: fluxon capacity per channel. A value of 1 reproduces classic DRO behaviour.
- BEGIN_CYCLES, 8: cycles after reset during which the block is uninitialised and ignores pulses.
- HOLD_CYCLES, 3: minimum separation, in cycles, between set and read pulses on a channel.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- set_i, in, CHANNELS: toggle-encoded set pulses, one bit per channel.
- read_i, in, 1: toggle-encoded read pulse, shared by all channels.
- out_o, out, CHANNELS: toggle-encoded readout pulses, one bit per channel.
- count_o, out, CHANNELS*$clog2(DEPTH+1): per-channel fluxon count. Channel k occupies slice k.
- ready_o, out, 1: high once the initialisation period has ended.
- overflow_o, out, CHANNELS: sticky flag; a set pulse arrived while the channel was full.
- viol_o, out, CHANNELS: sticky hold-violation flag (present only with the optional feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_o, count_o, overflow_o, viol_o, ready_o all go to 0.
  - Previous-sample registers for set_i and read_i load the current input values, so no spurious event is seen at release.
- Controller FSM, states INIT and RUN:
  - INIT: a cycle counter runs from 0. Pulse events are detected but discarded, and previous-sample registers still update.
  - INIT to RUN: when the counter reaches BEGIN_CYCLES-1; ready_o goes to 1 in the same registered update.
  - RUN: held until rst.
  - BEGIN_CYCLES=0: the block enters RUN on the first cycle after reset.
- Event detection:
  - set_ev[k] = set_i[k] XOR prev_set[k].
  - read_ev = read_i XOR prev_read.
  - Both are combinational from the registered previous sample.
- Per channel in RUN, using the pre-edge count c:
  - read_ev and c>0: out_o[k] toggles at the next edge (1-cycle latency) and c decrements.
  - read_ev and c==0: no output, no change.
  - set_ev and c<DEPTH: c increments.
  - set_ev and c==DEPTH: c is unchanged and overflow_o[k] is set.
  - set_ev and read_ev in the same cycle: the read acts on the pre-edge count, then the set is applied. With c=0 the result is no output and c=1. With 0<c<DEPTH the result is an output toggle and c unchanged. With c==DEPTH the result is an output toggle and c=DEPTH with no overflow, because the read frees the slot first.
- Reset mid-operation: stored fluxons are lost, out_o returns to 0, and the FSM re-enters INIT.
- count_o and out_o are registered outputs; there are no combinational paths from inputs.

Optional Feature:
- Macro: DRO_BANK_HOLD_CHECK_EN.
- Defined:
  - Each channel keeps two saturating counters (width $clog2(HOLD_CYCLES+1)): cycles since its last set_ev and cycles since the last read_ev. Both reset to the saturated value.
  - In RUN, set_ev[k] with cycles-since-read < HOLD_CYCLES sets viol_o[k].
  - read_ev with cycles-since-set[k] < HOLD_CYCLES also sets viol_o[k].
  - Simultaneous set_ev and read_ev on a channel always sets viol_o[k].
  - The violation is flagged only; data behaviour is unchanged. Flags are cleared only by rst.
- Undefined: viol_o is tied to 0 and the counters are not built.

Decomposition:
- Package dro_bank_pkg:
  - state enum {INIT, RUN}.
  - count-width function clog2_p1(n) = $clog2(n+1).
- One natural sub-module, dro_bank_cell: one channel holding count, out toggle, overflow and the hold counters.
- The top module holds the INIT/RUN FSM, read edge detection, a generate loop over CHANNELS, and count_o packing.

Test Plan:
- Init gating: reset, toggle set_i[0] at cycle 3 (before BEGIN_CYCLES=8), toggle read_i at cycle 12 -> out_o[0] stays 0, count 0, ready_o rises after cycle 8.
- Basic DRO (DEPTH=1): in RUN, set_i[1] toggles 1->0 (falling pulse), wait 5, read_i toggles -> out_o[1] toggles exactly 1 cycle later, count 1->0. A second read gives no toggle.
- Multi-fluxon (DEPTH=3): 4 set pulses 5 cycles apart on ch2 -> count 3, overflow_o[2]=1. Then 3 reads -> 3 out_o[2] toggles, count 0.
- Simultaneous events: with ch0 count 0, set and read on the same edge -> no toggle, count 1, viol_o[0]=1 (macro on) or 0 (macro off).
- Hold window (HOLD_CYCLES=3): read 2 cycles after set on ch3 -> viol_o[3]=1, and the output still toggles. Read 3 cycles after set on ch1 -> viol_o[1]=0.
- Reset mid-operation: ch0 count 1, out_o[0]=1, assert rst for one cycle -> all outputs 0, ready_o 0 for BEGIN_CYCLES, no spurious event from the held set_i level.
